// File: rtl/int_alu_pkg.sv
// Shared definitions for the sequential integer ALU blocks: FSM encodings,
// an index-width helper and the operand/chunk width sanity check.
`define INT_ALU_CHECK_MULTIPLE(W, C) \
    if (((W) % (C)) != 0) begin : g_width_check \
        $error("DATA_WIDTH must be an integer multiple of CHUNK_WIDTH"); \
    end

package int_alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

    // Counter width that stays legal even for a single-chunk configuration.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_sub_slice.sv
// One CHUNK_WIDTH slice of a ripple subtractor: a + ~b + cin, with the carry
// into the slice MSB exposed so the top level can derive signed overflow.
module int_sub_slice #(
    parameter int CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [CHUNK_WIDTH-1:0] diff,
    output logic                   cout,
    output logic                   c_msb_in
);

    logic [CHUNK_WIDTH:0] sum;

    assign sum  = {1'b0, a} + {1'b0, ~b} + {{CHUNK_WIDTH{1'b0}}, cin};
    assign diff = sum[CHUNK_WIDTH-1:0];
    assign cout = sum[CHUNK_WIDTH];

    // MSB sum bit is a ^ ~b ^ carry_in, so the carry in falls out by XOR.
    assign c_msb_in = sum[CHUNK_WIDTH-1] ^ a[CHUNK_WIDTH-1] ^ ~b[CHUNK_WIDTH-1];

endmodule

// File: rtl/int_subtractor_seq.sv
// Multi-cycle subtractor: data_a - data_b - borrow_in, one chunk per clock LSB
// first, with valid/ready on both sides and borrow/overflow/zero flags.
module int_subtractor_seq
    import int_alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  borrow_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  borrow_out,
    output logic                  overflow,
    output logic                  zero
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    `INT_ALU_CHECK_MULTIPLE(DATA_WIDTH, CHUNK_WIDTH)

    alu_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  carry_q, carry_d;
    logic [DATA_WIDTH-1:0] diff_q, diff_d;
    logic                  borrow_q, borrow_d;
    logic                  ovf_q, ovf_d;
    logic                  zero_q, zero_d;

    int                     base;
    logic [CHUNK_WIDTH-1:0] sl_diff;
    logic                   sl_cout;
    logic                   sl_cmsb;

    assign base = int'(idx_q) * CHUNK_WIDTH;

    int_sub_slice #(
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_slice (
        .a        (a_q[base +: CHUNK_WIDTH]),
        .b        (b_q[base +: CHUNK_WIDTH]),
        .cin      (carry_q),
        .diff     (sl_diff),
        .cout     (sl_cout),
        .c_msb_in (sl_cmsb)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = data_a;
                    b_d     = data_b;
                    carry_d = ~borrow_in;
                    idx_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                diff_d[base +: CHUNK_WIDTH] = sl_diff;
                carry_d = sl_cout;
                idx_d   = idx_q + 1'b1;
                // Final slice: flags see the fully assembled difference.
                if (idx_q == LAST_IDX) begin
                    borrow_d = ~sl_cout;
                    ovf_d    = sl_cmsb ^ sl_cout;
                    zero_d   = (diff_d == '0);
                    idx_d    = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_int_subtractor_seq.sv
// Scoreboard bench for int_subtractor_seq: expected results come from a
// plain-arithmetic model and are checked by an independent output monitor.
module tb_int_subtractor_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow_out;
    logic        overflow;
    logic        zero;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] diff;
        logic        borrow;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    int_subtractor_seq #(
        .DATA_WIDTH (32),
        .CHUNK_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .borrow_in (borrow_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow_out(borrow_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    // Reference: exact integer subtraction in 64 bits, unsigned and signed views.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        exp_t   e;
        longint ud;
        longint sd;
        longint bl;
        bl = bin ? 64'sd1 : 64'sd0;
        ud = longint'({32'd0, a}) - longint'({32'd0, b}) - bl;
        sd = longint'($signed(a)) - longint'($signed(b)) - bl;
        e.diff   = ud[31:0];
        e.borrow = (ud < 0);
        e.ovf    = (sd < -64'sd2147483648) || (sd > 64'sd2147483647);
        e.zero   = (e.diff == 32'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("in_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bin);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            data_a    = a;
            data_b    = b;
            borrow_in = bin;
            in_valid  = 1'b1;
            exp_q.push_back(model(a, b, bin));
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic drain(input bit random_bp);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            if (random_bp) out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0100 << (8 * $urandom_range(0, 2));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every accepted result is matched against the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("diff", 64'(diff), 64'(e.diff));
                    chk("borrow_out", 64'(borrow_out), 64'(e.borrow));
                    chk("overflow", 64'(overflow), 64'(e.ovf));
                    chk("zero", 64'(zero), 64'(e.zero));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        es;
        logic [31:0] ra;
        logic [31:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_a    = '0;
        data_b    = '0;
        borrow_in = 1'b0;

        @(posedge clk);
        @(negedge clk);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_borrow", 64'(borrow_out), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Latency: accept at E0, out_valid first seen after E4.
        tick();
        issue(32'd10, 32'd3, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk("latency_out_valid", 64'(out_valid), (k == 4) ? 64'd1 : 64'd0);
            if (k < 4) @(posedge clk);
        end
        drain(1'b0);

        issue(32'h0000_0100, 32'd1, 1'b0);          drain(1'b0);
        issue(32'd0, 32'd1, 1'b0);                  drain(1'b0);
        issue(32'h8000_0000, 32'd1, 1'b0);          drain(1'b0);
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);  drain(1'b0);
        issue(32'd5, 32'd4, 1'b1);                  drain(1'b0);
        issue(32'd0, 32'd0, 1'b1);                  drain(1'b0);

        // Backpressure: result held in DONE while inputs toggle.
        out_ready = 1'b0;
        issue(32'h1234_5678, 32'h0000_1111, 1'b0);
        es = model(32'h1234_5678, 32'h0000_1111, 1'b0);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            data_a    = $urandom;
            data_b    = $urandom;
            borrow_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_diff", 64'(diff), 64'(es.diff));
            chk("stall_flags", 64'({borrow_out, overflow, zero}), 64'({es.borrow, es.ovf, es.zero}));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        tick();
        issue(32'd1000, 32'd1, 1'b0);
        drain(1'b0);

        // Reset two cycles into BUSY aborts the operation.
        issue(32'd200, 32'd7, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_diff", 64'(diff), 64'd0);
        chk("abort_flags", 64'({borrow_out, overflow, zero}), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        tick();
        issue(32'd100, 32'd58, 1'b0);
        drain(1'b0);

        // Randomized operations with random output backpressure.
        for (int n = 0; n < 150; n++) begin
            ra = pick_operand();
            rb = pick_operand();
            issue(ra, rb, 1'($urandom_range(0, 1)));
            drain(1'b1);
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_subtractor_seq.md
Name: int_subtractor_seq

Overview:
Multi-cycle integer subtractor, the inverse-direction companion to the team's combinational ripple adder. Computes data_a - data_b - borrow_in by processing one CHUNK_WIDTH slice per clock, LSB first, with a registered borrow between slices. Uses a valid/ready handshake on both input and output so the ALU sequencer can use it with backpressure. It also produces unsigned borrow, signed overflow and zero flags.

Parameters:
DATA_WIDTH, 32, operand/result width.
CHUNK_WIDTH, 8, bits processed per cycle. DATA_WIDTH must be an integer multiple of it.
NUM_CHUNKS (localparam), DATA_WIDTH/CHUNK_WIDTH, number of BUSY cycles.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands and borrow_in are valid.
in_ready  output  1  block can accept an operation.
data_a  input  DATA_WIDTH  minuend.
data_b  input  DATA_WIDTH  subtrahend.
borrow_in  input  1  borrow into bit 0.
out_valid  output  1  result and flags are valid.
out_ready  input  1  consumer takes the result.
diff  output  DATA_WIDTH  data_a - data_b - borrow_in, modulo 2^DATA_WIDTH.
borrow_out  output  1  1 iff unsigned data_a < data_b + borrow_in.
overflow  output  1  signed two's-complement overflow.
zero  output  1  diff == 0.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high the block is in IDLE, and diff, borrow_out, overflow, zero, out_valid and the internal chunk counter are all 0. in_ready is 1 once reset deasserts.
- Arithmetic: each slice computes a_slice + ~b_slice + cin. cin for slice 0 is ~borrow_in. cin for each later slice is the registered carry out of the previous slice. borrow_out is the inverted carry out of the MSB slice. overflow is the carry into the MSB XOR the carry out of the MSB, captured in the last slice cycle. zero is registered when DONE is entered.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid & in_ready, capture data_a, data_b and ~borrow_in into registers, set chunk index to 0, and go to BUSY. in_valid alone has no effect in any other state.
- BUSY: in_ready=0. On each edge, write slice [idx] of diff, register the slice carry and increment idx. On the edge that processes slice NUM_CHUNKS-1, also register borrow_out, overflow and zero, and go to DONE.
- DONE: out_valid=1, in_ready=0. diff and the flags are held stable until out_ready is high. On out_valid & out_ready, go to IDLE and clear out_valid. diff and the flags keep their values until the next operation writes them.
- Latency: with the accept edge as E0, out_valid is first high after edge E(NUM_CHUNKS). With the defaults that is 4 clocks. Throughput is at most one operation per NUM_CHUNKS+2 cycles. An input accept cannot overlap a pending result.
- Operand registers are captured only at the accept edge. Changes on data_a, data_b or borrow_in during BUSY or DONE are ignored.
- Reset in the middle of an operation (BUSY or DONE) aborts it immediately. The pending result is discarded and every output returns to its reset value.

Decomposition:
- Shared package int_alu_pkg holds:
  - FSM state encodings S_IDLE, S_BUSY, S_DONE (2 bits).
  - A compile-time width check macro used to assert DATA_WIDTH % CHUNK_WIDTH == 0.
- Sub-module int_sub_slice is combinational, CHUNK_WIDTH wide. Inputs: a, b, cin. Outputs: diff, cout, and c_msb_in (the carry into its MSB, used for overflow). It is instantiated once and muxed by the chunk index.

Test Plan:
1. a=32'd10, b=32'd3, borrow_in=0 -> diff=7, borrow_out=0, overflow=0, zero=0. out_valid rises exactly 4 clocks after the accept edge.
2. a=32'h00000100, b=32'd1 -> diff=32'h000000FF, borrow_out=0. This checks borrow propagation across the chunk boundary. a=0, b=1 -> diff=32'hFFFFFFFF, borrow_out=1, overflow=0.
3. a=32'h80000000, b=1 -> diff=32'h7FFFFFFF, overflow=1, borrow_out=0. a=32'h7FFFFFFF, b=32'hFFFFFFFF -> diff=32'h80000000, overflow=1, borrow_out=1.
4. a=5, b=4, borrow_in=1 -> diff=0, zero=1, borrow_out=0. a=0, b=0, borrow_in=1 -> diff=32'hFFFFFFFF, borrow_out=1.
5. Hold out_ready=0 for 10 cycles in DONE, toggling in_valid and the operands -> out_valid, diff and flags stay stable and in_ready=0. Raise out_ready -> IDLE next cycle and the next accept proceeds.
6. Assert rst after 2 BUSY cycles -> all outputs 0 and in_ready=1 after release. A following 100-58 operation gives diff=42.
